// File: rtl/fwft_fifo_to_axis.sv
// FWFT FIFO read port to AXI4-Stream master through a 2-entry skid buffer.
// Fixed-length packet framing drives tlast; completed packets are counted.
module fwft_fifo_to_axis #(
    parameter int DATA_WIDTH    = 8,
    parameter int PKT_LEN       = 16,
    parameter int PKT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     enable,
    input  logic [DATA_WIDTH-1:0]    fwft_fifo_dout,
    input  logic                     fwft_fifo_empty,
    output logic                     fwft_fifo_rd_en,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [PKT_CNT_WIDTH-1:0] pkt_cnt
);

    localparam int BW = $clog2(PKT_LEN) + 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(PKT_LEN - 1);

    logic [1:0]               r_occ;
    logic [DATA_WIDTH-1:0]    r_head;
    logic [DATA_WIDTH-1:0]    r_tail;
    logic [BW-1:0]            r_beat;
    logic [PKT_CNT_WIDTH-1:0] r_pkt;

    logic w_push;
    logic w_pop;
    logic w_last;

    // Read enable sees only registered occupancy, never tready.
    assign w_push = enable & ~fwft_fifo_empty & (r_occ != 2'd2) & ~arst;
    assign w_pop  = m_axis_tvalid & m_axis_tready;
    assign w_last = m_axis_tvalid & (r_beat == LAST_IDX);

    assign fwft_fifo_rd_en = w_push;
    assign m_axis_tdata    = r_head;
    assign m_axis_tvalid   = (r_occ != 2'd0);
    assign m_axis_tlast    = w_last;
    assign pkt_cnt         = r_pkt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_occ  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            unique case (r_occ)
                2'd0: begin
                    if (w_push) begin
                        r_head <= fwft_fifo_dout;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= fwft_fifo_dout;
                    end else if (w_push) begin
                        r_tail <= fwft_fifo_dout;
                        r_occ  <= 2'd2;
                    end else if (w_pop) begin
                        r_occ  <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        r_occ  <= 2'd1;
                    end
                end
                default: r_occ <= 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_beat <= '0;
            r_pkt  <= '0;
        end else if (w_pop) begin
            if (w_last) begin
                r_beat <= '0;
                r_pkt  <= r_pkt + PKT_CNT_WIDTH'(1);
            end else begin
                r_beat <= r_beat + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwft_fifo_to_axis.sv
// Directed bench for fwft_fifo_to_axis: streaming, stall, random traffic,
// enable pause, asynchronous reset and single-beat packets.
module tb_fwft_fifo_to_axis;

    logic       clk;
    logic       arst;
    logic       enable;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       rd_en;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic [15:0] pkt_cnt;

    logic       b_arst;
    logic       b_en;
    logic [7:0] b_dout;
    logic       b_rd;
    logic [7:0] b_data;
    logic       b_v;
    logic       b_l;
    logic [3:0] b_pkt;

    int n_cmp;
    int n_fail;

    logic [7:0] q[$];
    logic [8:0] outq[$];
    int         out_cyc[$];
    int         cyc;
    int         occ_m;
    int         push_cnt;
    int         viol;
    logic       gap;
    logic       s_rd, s_v, s_r, s_l;
    logic [7:0] s_d;

    fwft_fifo_to_axis #(
        .DATA_WIDTH(8), .PKT_LEN(16), .PKT_CNT_WIDTH(16)
    ) dut (
        .clk(clk), .arst(arst), .enable(enable),
        .fwft_fifo_dout(fifo_dout), .fwft_fifo_empty(fifo_empty),
        .fwft_fifo_rd_en(rd_en),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast),
        .pkt_cnt(pkt_cnt)
    );

    fwft_fifo_to_axis #(
        .DATA_WIDTH(8), .PKT_LEN(1), .PKT_CNT_WIDTH(4)
    ) dut1 (
        .clk(clk), .arst(b_arst), .enable(b_en),
        .fwft_fifo_dout(b_dout), .fwft_fifo_empty(1'b0),
        .fwft_fifo_rd_en(b_rd),
        .m_axis_tdata(b_data), .m_axis_tvalid(b_v),
        .m_axis_tready(1'b1), .m_axis_tlast(b_l),
        .pkt_cnt(b_pkt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive FIFO view, sample pre-edge, then account the edge.
    task automatic cycle();
        fifo_empty = (q.size() == 0) || gap;
        fifo_dout  = (q.size() != 0) ? q[0] : 8'h00;
        #1;
        s_rd = rd_en; s_v = tvalid; s_r = tready;
        s_d = tdata; s_l = tlast;
        if (s_rd && (fifo_empty || occ_m == 2)) viol++;
        @(posedge clk);
        if (s_rd) begin
            void'(q.pop_front());
            push_cnt++;
        end
        if (s_v && s_r) begin
            outq.push_back({s_l, s_d});
            out_cyc.push_back(cyc);
        end
        occ_m = occ_m + (s_rd ? 1 : 0) - ((s_v && s_r) ? 1 : 0);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        arst = 1'b1; tready = 1'b0; enable = 1'b0; gap = 1'b0;
        q.delete(); outq.delete(); out_cyc.delete();
        occ_m = 0; push_cnt = 0; viol = 0;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        arst = 1'b1; b_arst = 1'b1;
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(8'hA0 + 8'(i));
        enable = 1'b1; tready = 1'b1; gap = 1'b0;
        fifo_empty = 1'b0; fifo_dout = 8'hA0;
        @(negedge clk); #1;
        n_cmp++;
        if (rd_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_rd_en: got %b expected 0", rd_en);
        end
        n_cmp++;
        if (tvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_tvalid: got %b expected 0", tvalid);
        end
        n_cmp++;
        if (tlast !== 1'b0) begin
            n_fail++; $display("FAIL reset_tlast: got %b expected 0", tlast);
        end
        n_cmp++;
        if (pkt_cnt !== 16'd0 || tdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_regs: pkt_cnt %h tdata %h expected 0 0",
                     pkt_cnt, tdata);
        end
        @(negedge clk);
        arst = 1'b0; b_arst = 1'b0;
        #1;
        n_cmp++;
        if (rd_en !== 1'b1 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL release: rd_en %b tvalid %b expected 1 0",
                     rd_en, tvalid);
        end
        @(negedge clk);
    endtask

    task automatic test_stream();
        int first_rd;
        int first_v;
        do_reset();
        for (int i = 0; i < 32; i++) q.push_back(8'(i));
        tready = 1'b1; enable = 1'b1;
        first_rd = -1; first_v = -1;
        for (int k = 0; k < 80 && outq.size() < 32; k++) begin
            cycle();
            if (s_rd && first_rd < 0) first_rd = cyc - 1;
            if (s_v && first_v < 0) first_v = cyc - 1;
        end
        n_cmp++;
        if (outq.size() != 32) begin
            n_fail++;
            $display("FAIL stream_count: got %0d expected 32", outq.size());
        end
        for (int i = 0; i < outq.size(); i++) begin
            n_cmp++;
            if (outq[i] !== {(i == 15 || i == 31), 8'(i)}) begin
                n_fail++;
                $display("FAIL stream_beat[%0d]: got %h expected %h", i,
                         outq[i], {(i == 15 || i == 31), 8'(i)});
            end
        end
        n_cmp++;
        if (first_v != first_rd + 1) begin
            n_fail++;
            $display("FAIL stream_latency: tvalid cycle %0d expected %0d",
                     first_v, first_rd + 1);
        end
        if (outq.size() == 32) begin
            n_cmp++;
            if (out_cyc[31] - out_cyc[0] != 31) begin
                n_fail++;
                $display("FAIL stream_rate: span %0d expected 31",
                         out_cyc[31] - out_cyc[0]);
            end
        end
        n_cmp++;
        if (pkt_cnt !== 16'd2) begin
            n_fail++; $display("FAIL stream_pkt_cnt: got %0d expected 2", pkt_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 32; i++) q.push_back(8'(i));
        tready = 1'b1; enable = 1'b1;
        for (int k = 0; k < 30 && outq.size() < 6; k++) cycle();
        tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_cmp++;
            if (s_v !== 1'b1 || s_d !== 8'h06) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: tvalid %b tdata %h expected 1 06",
                         k, s_v, s_d);
            end
        end
        n_cmp++;
        if (push_cnt != 8 || s_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_reads: pushes %0d rd_en %b expected 8 0",
                     push_cnt, s_rd);
        end
        tready = 1'b1;
        repeat (3) cycle();
        n_cmp++;
        if (outq.size() != 9) begin
            n_fail++;
            $display("FAIL stall_resume_count: got %0d expected 9", outq.size());
        end else begin
            for (int i = 6; i < 9; i++) begin
                n_cmp++;
                if (outq[i][7:0] !== 8'(i)) begin
                    n_fail++;
                    $display("FAIL stall_resume[%0d]: got %h expected %h",
                             i, outq[i][7:0], 8'(i));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_w[$];
        int bad;
        do_reset();
        for (int i = 0; i < 1000; i++) exp_w.push_back(8'($urandom));
        q = exp_w;
        enable = 1'b1;
        for (int k = 0; k < 8000 && outq.size() < 1000; k++) begin
            gap = ($urandom_range(0, 3) == 0);
            tready = 1'($urandom_range(0, 1));
            cycle();
        end
        gap = 1'b0;
        n_cmp++;
        if (outq.size() != 1000) begin
            n_fail++;
            $display("FAIL random_count: got %0d expected 1000", outq.size());
        end
        bad = 0;
        for (int i = 0; i < outq.size(); i++)
            if (outq[i][7:0] !== exp_w[i]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL random_seq: %0d wrong beats expected 0", bad);
        end
        n_cmp++;
        if (viol != 0) begin
            n_fail++; $display("FAIL random_rd_en: %0d bad reads expected 0", viol);
        end
        n_cmp++;
        if (pkt_cnt !== 16'd62) begin
            n_fail++; $display("FAIL random_pkt_cnt: got %0d expected 62", pkt_cnt);
        end
    endtask

    task automatic test_enable();
        int rd_seen;
        do_reset();
        for (int i = 0; i < 32; i++) q.push_back(8'(i));
        tready = 1'b1; enable = 1'b1;
        for (int k = 0; k < 30 && outq.size() < 5; k++) cycle();
        tready = 1'b0;
        cycle();
        enable = 1'b0; tready = 1'b1;
        rd_seen = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (s_rd) rd_seen++;
        end
        n_cmp++;
        if (rd_seen != 0 || outq.size() != 7) begin
            n_fail++;
            $display("FAIL enable_pause: reads %0d beats %0d expected 0 7",
                     rd_seen, outq.size());
        end
        enable = 1'b1;
        for (int k = 0; k < 40 && outq.size() < 16; k++) cycle();
        n_cmp++;
        if (outq.size() != 16) begin
            n_fail++;
            $display("FAIL enable_count: got %0d expected 16", outq.size());
        end
        for (int i = 0; i < outq.size(); i++) begin
            n_cmp++;
            if (outq[i] !== {(i == 15), 8'(i)}) begin
                n_fail++;
                $display("FAIL enable_beat[%0d]: got %h expected %h", i,
                         outq[i], {(i == 15), 8'(i)});
            end
        end
        n_cmp++;
        if (pkt_cnt !== 16'd1) begin
            n_fail++; $display("FAIL enable_pkt_cnt: got %0d expected 1", pkt_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 64; i++) q.push_back(8'(i));
        tready = 1'b1; enable = 1'b1;
        for (int k = 0; k < 60 && outq.size() < 25; k++) cycle();
        tready = 1'b0;
        cycle();
        n_cmp++;
        if (pkt_cnt !== 16'd1 || tvalid !== 1'b1 || tdata !== 8'd25) begin
            n_fail++;
            $display("FAIL arst_pre: pkt_cnt %0d tvalid %b tdata %h expected 1 1 19",
                     pkt_cnt, tvalid, tdata);
        end
        #2 arst = 1'b1;
        #1;
        n_cmp++;
        if (tvalid !== 1'b0 || rd_en !== 1'b0 || tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_now: tvalid %b rd_en %b tlast %b expected 0 0 0",
                     tvalid, rd_en, tlast);
        end
        n_cmp++;
        if (pkt_cnt !== 16'd0) begin
            n_fail++; $display("FAIL arst_pkt_cnt: got %0d expected 0", pkt_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        outq.delete(); out_cyc.delete(); occ_m = 0;
        tready = 1'b1;
        for (int k = 0; k < 40 && outq.size() < 16; k++) cycle();
        n_cmp++;
        if (outq.size() != 16) begin
            n_fail++;
            $display("FAIL arst_count: got %0d expected 16", outq.size());
        end
        for (int i = 0; i < outq.size(); i++) begin
            n_cmp++;
            if (outq[i] !== {(i == 15), 8'(27 + i)}) begin
                n_fail++;
                $display("FAIL arst_beat[%0d]: got %h expected %h", i,
                         outq[i], {(i == 15), 8'(27 + i)});
            end
        end
        n_cmp++;
        if (pkt_cnt !== 16'd1) begin
            n_fail++; $display("FAIL arst_pkt_after: got %0d expected 1", pkt_cnt);
        end
    endtask

    task automatic test_pktlen1();
        int pushes;
        int pops;
        logic v;
        logic l;
        pushes = 0; pops = 0;
        for (int k = 0; k < 40; k++) begin
            b_en = (pushes < 20);
            b_dout = 8'(pushes);
            #1;
            v = b_v; l = b_l;
            if (b_rd) pushes++;
            if (v) begin
                pops++;
                n_cmp++;
                if (l !== 1'b1) begin
                    n_fail++;
                    $display("FAIL len1_tlast[%0d]: got %b expected 1", pops, l);
                end
            end
            @(posedge clk); #1;
            if (v && pops == 15) begin
                n_cmp++;
                if (b_pkt !== 4'd15) begin
                    n_fail++; $display("FAIL len1_cnt15: got %0d expected 15", b_pkt);
                end
            end
            if (v && pops == 16) begin
                n_cmp++;
                if (b_pkt !== 4'd0) begin
                    n_fail++; $display("FAIL len1_wrap: got %0d expected 0", b_pkt);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (pops != 20 || b_pkt !== 4'd4 || b_v !== 1'b0) begin
            n_fail++;
            $display("FAIL len1_end: beats %0d pkt_cnt %0d tvalid %b expected 20 4 0",
                     pops, b_pkt, b_v);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0;
        occ_m = 0; push_cnt = 0; viol = 0; gap = 1'b0;
        arst = 1'b1; enable = 1'b0; tready = 1'b0;
        fifo_empty = 1'b1; fifo_dout = 8'h00;
        b_arst = 1'b1; b_en = 1'b0; b_dout = 8'h00;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_random();
        test_enable();
        test_async_reset();
        test_pktlen1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fwft_fifo_to_axis.md
Name: fwft_fifo_to_axis

Overview:
- Downstream stage for the FWFT read port, whether produced by the standard-to-FWFT converter or by a native FWFT FIFO.
- Turns the dout/empty/rd_en interface into an AXI4-Stream master with tvalid/tready/tlast.
- A 2-entry skid buffer keeps the FIFO read enable free of any combinational path from tready while sustaining 1 beat/cycle.
- tlast is generated from a fixed packet length, and completed packets are counted.

Parameters:
- DATA_WIDTH, 8, width of fwft_fifo_dout and m_axis_tdata.
- PKT_LEN, 16, beats per packet; legal range 1..65535; tlast marks beat PKT_LEN-1.
- PKT_CNT_WIDTH, 16, width of the completed-packet counter; wraps modulo 2^PKT_CNT_WIDTH.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- arst  in  1  asynchronous active-high reset; asserts immediately, released synchronously by the system.
- enable  in  1  when 0, no new FIFO reads are issued; buffered beats still drain.
- fwft_fifo_dout  in  DATA_WIDTH  head word of the FWFT FIFO, valid whenever fwft_fifo_empty=0.
- fwft_fifo_empty  in  1  FWFT FIFO empty.
- fwft_fifo_rd_en  out  1  pops the head word in the same cycle.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready from the consumer.
- m_axis_tlast  out  1  last beat of the current packet.
- pkt_cnt  out  PKT_CNT_WIDTH  number of packets fully accepted (tlast beat handshaken).

Behaviour:
- Storage:
  - Two registered entries, head (H) and tail (T), with occupancy occ in 0..2.
  - m_axis_tdata = H.data; m_axis_tvalid = (occ != 0).
- Read enable: fwft_fifo_rd_en = enable & ~fwft_fifo_empty & (occ != 2).
  - Depends only on registers and the FIFO/enable inputs; never on m_axis_tready.
- push = fwft_fifo_rd_en; pop = m_axis_tvalid & m_axis_tready. occ_next = occ + push - pop.
  - occ=0, push: word -> H.
  - occ=1, push, no pop: word -> T.
  - occ=1, push & pop: word -> H.
  - occ=2, pop: T -> H (push impossible at occ=2).
- Latency:
  - A word popped from the FIFO at edge N appears on m_axis_tdata with tvalid=1 in the cycle after N.
  - With tready held at 1, the block streams one beat per cycle at occ=1.
- Stall: when tready drops, at most one extra word is absorbed (occ 1->2), then rd_en deasserts.
  - H.data and tvalid stay stable while tvalid=1 & tready=0 (AXI rule); no beat is dropped or duplicated.
- tlast:
  - beat_idx, a counter of width clog2(PKT_LEN)+1, counts accepted beats.
  - m_axis_tlast = m_axis_tvalid & (beat_idx == PKT_LEN-1).
  - On pop: if tlast, beat_idx <= 0 and pkt_cnt <= pkt_cnt+1 (wraps to 0); else beat_idx <= beat_idx+1.
  - PKT_LEN=1: every valid beat has tlast=1.
- enable:
  - Deassertion blocks new pushes in the same cycle; buffered beats (up to 2) still drain normally.
  - beat_idx is not reset by enable, so packet framing persists across pauses.
- FIFO empty: no push; the stream goes idle (tvalid=0) once occ reaches 0. Words arriving later continue the same packet.
- Reset (arst=1, any time including mid-packet):
  - Immediately: occ=0, tvalid=0, tlast=0, beat_idx=0, pkt_cnt=0, H/T data=0, and fwft_fifo_rd_en=0 for as long as arst=1.
  - Buffered words are discarded.
  - After release, the first accepted beat is beat 0 of a new packet.
- X-safety: fwft_fifo_dout is sampled only when push=1.

Test Plan:
- Stream 32 words 0x00..0x1F with tready=1, PKT_LEN=16 -> tdata 0x00..0x1F on consecutive cycles; first tvalid one cycle after the first rd_en; tlast on 0x0F and 0x1F; pkt_cnt=2.
- Stall after 0x05 accepted, tready=0 for 5 cycles -> rd_en stops after exactly 2 buffered words (0x06, 0x07); tdata holds 0x06; after tready=1, output continues 0x06, 0x07, 0x08 with no gap or loss.
- Random tready (50%) plus random FIFO empty gaps, 1000 words -> output sequence equals input sequence; fwft_fifo_rd_en never asserts while occ=2 or fwft_fifo_empty=1.
- enable=0 for 10 cycles mid-packet at beat 5 with 2 words buffered -> those 2 beats drain, no rd_en during the pause; after enable=1, tlast lands on the 16th overall beat of that packet.
- arst pulse asserted asynchronously (mid-cycle) with occ=2 at beat 9 -> tvalid/rd_en/tlast drop to 0 immediately and pkt_cnt=0; post-reset, tlast lands on the 16th beat counted from the first post-reset beat.
- PKT_LEN=1, PKT_CNT_WIDTH=4, 20 beats -> tlast=1 on every beat; pkt_cnt wraps 15->0 and ends at 4.
